// File: rtl/eth_pkg.sv
// rtl/eth_pkg.sv - shared UDP framer types, constants and header byte select
package eth_pkg;

    localparam int UDP_HDR_LEN = 8;

    typedef enum logic [1:0] {
        IDLE,
        HEADER,
        PAYLOAD,
        DRAIN
    } udp_tx_state_t;

    // Header is big-endian on the wire; the checksum bytes are always zero.
    function automatic logic [7:0] udp_hdr_byte(
        input logic [15:0] port_s,
        input logic [15:0] port_d,
        input logic [15:0] len,
        input logic [2:0]  idx
    );
        case (idx)
            3'd0:    return port_s[15:8];
            3'd1:    return port_s[7:0];
            3'd2:    return port_d[15:8];
            3'd3:    return port_d[7:0];
            3'd4:    return len[15:8];
            3'd5:    return len[7:0];
            default: return 8'h00;
        endcase
    endfunction

endpackage

// File: rtl/udp_header_tx_if.sv
// rtl/udp_header_tx_if.sv - command, payload and segment stream bundle of the UDP framer
interface udp_header_tx_if;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [15:0] port_s;
    logic [15:0] port_d;
    logic [15:0] payload_len;
    logic [7:0]  s_tdata;
    logic        s_tvalid;
    logic        s_tready;
    logic        s_tlast;
    logic [7:0]  m_tdata;
    logic        m_tvalid;
    logic        m_tready;
    logic        m_tlast;
    logic        len_err;

    modport slave (
        input  cmd_valid, port_s, port_d, payload_len,
        input  s_tdata, s_tvalid, s_tlast, m_tready,
        output cmd_ready, s_tready, m_tdata, m_tvalid, m_tlast, len_err
    );

    modport master (
        output cmd_valid, port_s, port_d, payload_len,
        output s_tdata, s_tvalid, s_tlast, m_tready,
        input  cmd_ready, s_tready, m_tdata, m_tvalid, m_tlast, len_err
    );
endinterface

// File: rtl/udp_header_tx.sv
// rtl/udp_header_tx.sv - prepends an 8-byte UDP header to a byte-serial payload stream
module udp_header_tx
    import eth_pkg::*;
#(
    parameter int MAX_PAYLOAD = 1472
) (
    input  logic           aclk,
    input  logic           aresetn,
    udp_header_tx_if.slave bus
);

    localparam logic [2:0] HDR_LAST = 3'(UDP_HDR_LEN - 1);

    udp_tx_state_t state_q, state_d;
    logic [2:0]    idx_q, idx_d;
    logic [15:0]   cnt_q, cnt_d;
    logic [15:0]   port_s_q, port_d_q, len_q, udp_len_q;
    logic          cmd_ready_q, len_err_q;
    logic          err_d, cmd_acc, last_cnt;

    // Written as cnt+1 == len so the zero-length case never wraps.
    assign last_cnt      = ((cnt_q + 16'd1) == len_q);
    assign bus.cmd_ready = cmd_ready_q;
    assign bus.len_err   = len_err_q;

    always_comb begin
        state_d      = state_q;
        idx_d        = idx_q;
        cnt_d        = cnt_q;
        err_d        = 1'b0;
        cmd_acc      = 1'b0;
        bus.s_tready = 1'b0;
        bus.m_tvalid = 1'b0;
        bus.m_tdata  = 8'h00;
        bus.m_tlast  = 1'b0;
        case (state_q)
            IDLE: begin
                if (bus.cmd_valid && cmd_ready_q) begin
                    cmd_acc = 1'b1;
                    if (bus.payload_len > 16'(MAX_PAYLOAD)) begin
                        err_d = 1'b1;
                    end else begin
                        state_d = HEADER;
                        idx_d   = 3'd0;
                    end
                end
            end
            HEADER: begin
                bus.m_tvalid = 1'b1;
                bus.m_tdata  = udp_hdr_byte(port_s_q, port_d_q, udp_len_q, idx_q);
                bus.m_tlast  = (idx_q == HDR_LAST) && (len_q == 16'd0);
                if (bus.m_tready) begin
                    if (idx_q == HDR_LAST) begin
                        state_d = (len_q == 16'd0) ? IDLE : PAYLOAD;
                        cnt_d   = 16'd0;
                    end else begin
                        idx_d = idx_q + 3'd1;
                    end
                end
            end
            PAYLOAD: begin
                bus.m_tdata  = bus.s_tdata;
                bus.m_tvalid = bus.s_tvalid;
                bus.s_tready = bus.m_tready;
                bus.m_tlast  = last_cnt || bus.s_tlast;
                if (bus.s_tvalid && bus.m_tready) begin
                    cnt_d = cnt_q + 16'd1;
                    if (bus.s_tlast) begin
                        state_d = IDLE;
                        err_d   = !last_cnt;
                    end else if (last_cnt) begin
                        state_d = DRAIN;
                        err_d   = 1'b1;
                    end
                end
            end
            DRAIN: begin
                bus.s_tready = 1'b1;
                if (bus.s_tvalid && bus.s_tlast) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            state_q     <= IDLE;
            idx_q       <= 3'd0;
            cnt_q       <= 16'd0;
            port_s_q    <= 16'd0;
            port_d_q    <= 16'd0;
            len_q       <= 16'd0;
            udp_len_q   <= 16'd0;
            cmd_ready_q <= 1'b0;
            len_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            cnt_q       <= cnt_d;
            cmd_ready_q <= (state_d == IDLE);
            len_err_q   <= err_d;
            if (cmd_acc) begin
                port_s_q  <= bus.port_s;
                port_d_q  <= bus.port_d;
                len_q     <= bus.payload_len;
                udp_len_q <= bus.payload_len + 16'(UDP_HDR_LEN);
            end
        end
    end

endmodule

// File: tb/tb_udp_header_tx.sv
// tb/tb_udp_header_tx.sv - randomized self-checking bench for udp_header_tx
module tb_udp_header_tx;

    localparam int MAX = 1472;

    logic aclk = 1'b0;
    logic aresetn = 1'b0;
    always #5 aclk = ~aclk;

    udp_header_tx_if bus ();
    udp_header_tx #(.MAX_PAYLOAD(MAX)) dut (.aclk(aclk), .aresetn(aresetn), .bus(bus));

    int         errors = 0;
    int         checks = 0;
    int         err_cnt = 0;
    bit         srdy_seen = 1'b0;
    bit         rand_ready = 1'b0;
    logic [8:0] exp_q[$];
    logic [8:0] out_log[$];
    logic [8:0] src_q[$];
    logic [7:0] pl_q[$];

    logic [8:0] lit1[12] = '{9'h012, 9'h034, 9'h004, 9'h000, 9'h000, 9'h00C,
                             9'h000, 9'h000, 9'h0DE, 9'h0AD, 9'h0BE, 9'h1EF};
    logic [8:0] lit2[8]  = '{9'h0AB, 9'h0CD, 9'h000, 9'h035, 9'h000, 9'h008,
                             9'h000, 9'h100};

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Upstream payload source: holds an offered byte until it is taken.
    initial begin
        bit hs;
        bus.s_tvalid = 1'b0;
        bus.s_tdata  = 8'h00;
        bus.s_tlast  = 1'b0;
        forever begin
            @(negedge aclk);
            hs = bus.s_tvalid && bus.s_tready;
            @(posedge aclk);
            #1;
            if (hs && src_q.size() > 0) void'(src_q.pop_front());
            if (src_q.size() == 0) begin
                bus.s_tvalid = 1'b0;
            end else if (!(bus.s_tvalid && !hs)) begin
                bus.s_tvalid = ($urandom_range(0, 3) != 0);
                bus.s_tdata  = src_q[0][7:0];
                bus.s_tlast  = src_q[0][8];
            end
        end
    end

    initial begin
        bus.m_tready = 1'b1;
        forever begin
            @(posedge aclk);
            #1;
            bus.m_tready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
        end
    end

    // Output compare: every accepted byte against the model queue.
    initial begin
        bit         prev_stall;
        logic [7:0] prev_data;
        logic [8:0] e;
        prev_stall = 1'b0;
        prev_data  = 8'h00;
        forever begin
            @(negedge aclk);
            if (!aresetn) begin
                prev_stall = 1'b0;
            end else begin
                if (bus.len_err) err_cnt++;
                if (bus.s_tready) srdy_seen = 1'b1;
                if (prev_stall && bus.m_tvalid)
                    chk("stall_hold", 32'(bus.m_tdata), 32'(prev_data));
                if (bus.m_tvalid && bus.m_tready) begin
                    out_log.push_back({bus.m_tlast, bus.m_tdata});
                    if (exp_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_byte: got %0h expected none", {bus.m_tlast, bus.m_tdata});
                    end else begin
                        e = exp_q.pop_front();
                        chk("byte", 32'({bus.m_tlast, bus.m_tdata}), 32'(e));
                    end
                end
                prev_stall = bus.m_tvalid && !bus.m_tready;
                prev_data  = bus.m_tdata;
            end
        end
    end

    task automatic fill(input int n);
        pl_q.delete();
        repeat (n) pl_q.push_back(8'($urandom_range(0, 255)));
    endtask

    // Reference model: header fields by arithmetic, payload truncated at the shorter of len/tlast.
    task automatic load_frame(input logic [15:0] ps, input logic [15:0] pd, input logic [15:0] len,
                              output int exp_err);
        int n;
        int k;
        logic [15:0] ulen;
        n = pl_q.size();
        exp_q.delete();
        out_log.delete();
        err_cnt   = 0;
        srdy_seen = 1'b0;
        ulen = len + 16'd8;
        if (int'(len) > MAX) begin
            exp_err = 1;
        end else begin
            exp_q.push_back({1'b0, ps[15:8]});
            exp_q.push_back({1'b0, ps[7:0]});
            exp_q.push_back({1'b0, pd[15:8]});
            exp_q.push_back({1'b0, pd[7:0]});
            exp_q.push_back({1'b0, ulen[15:8]});
            exp_q.push_back({1'b0, ulen[7:0]});
            exp_q.push_back(9'h000);
            exp_q.push_back(9'h000);
            k = (int'(len) < n) ? int'(len) : n;
            for (int i = 0; i < k; i++) exp_q.push_back({1'b0, pl_q[i]});
            exp_q[exp_q.size() - 1][8] = 1'b1;
            exp_err = (len != 16'd0 && n != int'(len)) ? 1 : 0;
        end
        for (int i = 0; i < n; i++) src_q.push_back({(i == n - 1), pl_q[i]});
    endtask

    task automatic send_cmd(input logic [15:0] ps, input logic [15:0] pd, input logic [15:0] len);
        int t;
        @(posedge aclk);
        #1;
        bus.cmd_valid   = 1'b1;
        bus.port_s      = ps;
        bus.port_d      = pd;
        bus.payload_len = len;
        t = 0;
        forever begin
            @(negedge aclk);
            if (bus.cmd_ready || t > 100) break;
            t++;
        end
        chk("cmd_accept_timeout", 32'(t <= 100), 32'd1);
        @(posedge aclk);
        #1;
        bus.cmd_valid = 1'b0;
        @(negedge aclk);
        chk("cmd_ready_after_accept", 32'(bus.cmd_ready), 32'(int'(len) > MAX));
    endtask

    task automatic run_frame(input logic [15:0] ps, input logic [15:0] pd, input logic [15:0] len,
                             input bit rr);
        int exp_err;
        int t;
        rand_ready = rr;
        load_frame(ps, pd, len, exp_err);
        send_cmd(ps, pd, len);
        t = 0;
        while ((exp_q.size() != 0 || src_q.size() != 0) && t < 20000) begin
            @(negedge aclk);
            t++;
        end
        chk("frame_timeout", 32'(t < 20000), 32'd1);
        repeat (3) @(negedge aclk);
        chk("len_err_pulses", 32'(err_cnt), 32'(exp_err));
        if (pl_q.size() == 0) chk("s_tready_never", 32'(srdy_seen), 32'd0);
    endtask

    initial begin
        int ee;
        int t;
        int len;
        int n;
        bus.cmd_valid   = 1'b0;
        bus.port_s      = 16'h0;
        bus.port_d      = 16'h0;
        bus.payload_len = 16'h0;
        repeat (3) @(negedge aclk);
        chk("rst_m_tvalid", 32'(bus.m_tvalid), 32'd0);
        chk("rst_m_tlast", 32'(bus.m_tlast), 32'd0);
        chk("rst_s_tready", 32'(bus.s_tready), 32'd0);
        chk("rst_len_err", 32'(bus.len_err), 32'd0);
        chk("rst_cmd_ready", 32'(bus.cmd_ready), 32'd0);
        @(posedge aclk);
        #1;
        aresetn = 1'b1;

        for (int pass = 0; pass < 2; pass++) begin
            pl_q = '{8'hDE, 8'hAD, 8'hBE, 8'hEF};
            run_frame(16'h1234, 16'h0400, 16'd4, pass == 1);
            chk("lit1_count", 32'(out_log.size()), 32'd12);
            for (int i = 0; i < 12 && i < out_log.size(); i++)
                chk("lit1_byte", 32'(out_log[i]), 32'(lit1[i]));
        end

        pl_q.delete();
        run_frame(16'hABCD, 16'h0035, 16'd0, 1'b0);
        chk("lit2_count", 32'(out_log.size()), 32'd8);
        for (int i = 0; i < 8 && i < out_log.size(); i++)
            chk("lit2_byte", 32'(out_log[i]), 32'(lit2[i]));

        fill(2);
        run_frame(16'h1111, 16'h2222, 16'd4, 1'b1);
        chk("short_count", 32'(out_log.size()), 32'd10);

        fill(5);
        run_frame(16'h3333, 16'h4444, 16'd2, 1'b1);
        chk("long_count", 32'(out_log.size()), 32'd10);

        pl_q.delete();
        run_frame(16'h5555, 16'h6666, 16'(MAX + 1), 1'b0);
        chk("oversize_count", 32'(out_log.size()), 32'd0);

        fill(MAX);
        run_frame(16'h7777, 16'h8888, 16'(MAX), 1'b0);
        chk("max_count", 32'(out_log.size()), 32'(MAX + 8));

        for (int r = 0; r < 25; r++) begin
            len = $urandom_range(0, 24);
            if (len == 0) n = 0;
            else if ($urandom_range(0, 2) == 0) n = $urandom_range(1, len + 4);
            else n = len;
            if ($urandom_range(0, 9) == 0) begin
                len = MAX + 1 + $urandom_range(0, 100);
                n   = 0;
            end
            fill(n);
            run_frame(16'($urandom), 16'($urandom), 16'(len), 1'($urandom_range(0, 1)));
        end

        // Reset in the middle of the header.
        fill(4);
        rand_ready = 1'b0;
        load_frame(16'h9999, 16'hAAAA, 16'd4, ee);
        send_cmd(16'h9999, 16'hAAAA, 16'd4);
        t = 0;
        while (out_log.size() < 3 && t < 100) begin
            @(negedge aclk);
            t++;
        end
        chk("mid_hdr_timeout", 32'(t < 100), 32'd1);
        @(posedge aclk);
        #1;
        aresetn = 1'b0;
        #1;
        chk("rst_mid_m_tvalid", 32'(bus.m_tvalid), 32'd0);
        chk("rst_mid_m_tlast", 32'(bus.m_tlast), 32'd0);
        @(negedge aclk);
        chk("rst_mid_cmd_ready", 32'(bus.cmd_ready), 32'd0);
        src_q.delete();
        exp_q.delete();
        @(posedge aclk);
        #1;
        aresetn = 1'b1;
        repeat (2) @(negedge aclk);
        chk("post_rst_cmd_ready", 32'(bus.cmd_ready), 32'd1);
        fill(3);
        run_frame(16'hBBBB, 16'hCCCC, 16'd3, 1'b1);
        chk("post_rst_count", 32'(out_log.size()), 32'd11);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
